// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: buffers command/data bytes in a small FIFO and writes each
// one to an HD44780-style LCD with registered setup / E-pulse / hold timing,
// then waits out the controller execution time before the next byte.
module lcd_bus_driver #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned T_SETUP     = 1,
  parameter int unsigned T_PW        = 2,
  parameter int unsigned T_HOLD      = 1,
  parameter int unsigned T_EXEC      = 40,
  parameter int unsigned T_EXEC_LONG = 1600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       busy,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned M0   = (T_EXEC_LONG > T_EXEC) ? T_EXEC_LONG : T_EXEC;
  localparam int unsigned M1   = (M0 > T_PW) ? M0 : T_PW;
  localparam int unsigned M2   = (M1 > T_SETUP) ? M1 : T_SETUP;
  localparam int unsigned CMAX = (M2 > T_HOLD) ? M2 : T_HOLD;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] PW_LAST    = CW'(T_PW - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] EXEC_LAST  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(T_EXEC_LONG - 1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNTF_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNTF_FULL  = (AW+1)'(DEPTH);

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [8:0]    head;
  logic          push, pop;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          e_q, e_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          long_q, long_d;

  assign head     = mem_q[rd_ptr_q];
  assign in_ready = (count_q != CNTF_FULL);
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == S_IDLE) & (count_q != '0);
  assign busy     = (state_q != S_IDLE) | (count_q != '0);

  assign LCD_E    = e_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_DATA = data_q;

  // FIFO storage: entries are {rs, data}
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_rs, in_data};
  end

  // FIFO pointers and occupancy; push and pop on one edge leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_q <= count_q + CNTF_ONE;
      else if (!push && pop) count_q <= count_q - CNTF_ONE;
    end
  end

  // Next-state logic: the bus is loaded only on the IDLE pop, E is registered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    e_d     = 1'b0;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (count_q != '0) begin
          rs_d    = head[8];
          data_d  = head[7:0];
          long_d  = !head[8] && ((head[7:0] == 8'h01) || (head[7:0] == 8'h02) ||
                                 (head[7:0] == 8'h03));
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          e_d     = 1'b1;
          cnt_d   = '0;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        e_d = 1'b1;
        if (cnt_q == PW_LAST) begin
          e_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == (long_q ? LONG_LAST : EXEC_LAST)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer and LCD pin registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
    end
  end

endmodule
